sc_stream_decoder: RTL and testbench
====================================

# sc_stream_decoder

Receive-side stochastic-to-binary decoder for the progressive-precision early-termination datapath. It accepts a serial stochastic bitstream over a valid/ready handshake and counts ones over a window of 2^(ell+NC) accepted samples, where ell is the precision level chosen for this conversion. It then returns a full-scale TW-bit binary estimate over a second valid/ready handshake. It is the downstream counterpart of the bitstream generator: the generator emits the bitstream, and this block terminates it and rebuilds the binary word.

## Interface
Parameters
- W, 8: maximum binary precision in bits; ell is clamped to W.
- NC, 0: extra correlation bits; window length is 2^(ell+NC).
- TW, localparam = W+NC: output word width.
- LW, localparam = $clog2(W+1): width of the ell port.

Ports
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  request a conversion; sampled only in IDLE.
- ell  in  LW  precision level; latched with start; values above W are clamped to W.
- abort  in  1  cancels an in-progress conversion; no result is produced.
- z  in  1  stochastic bitstream sample.
- z_valid  in  1  z is valid this cycle.
- z_ready  out  1  block accepts z this cycle.
- bz  out  TW  binary result; stable while bz_valid is high.
- bz_valid  out  1  result available.
- bz_ready  in  1  consumer takes the result.
- busy  out  1  high in ACC or HOLD.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE
  - z_ready=0, bz_valid=0.
  - On start=1: latch ell_q = min(ell, W), clear the sample counter n and the ones counter c, then go to ACC.
- ACC
  - z_ready=1.
  - A sample is accepted when z_valid & z_ready. On acceptance, n increments and c increments if z=1.
  - When the accepted sample makes n = 2^(ell_q+NC), compute bz and go to HOLD.
  - Cycles with z_valid=0 change nothing.
- HOLD
  - z_ready=0, bz_valid=1, bz held.
  - On bz_ready=1, go to IDLE.
- Abort
  - In ACC or HOLD, abort=1 forces IDLE next cycle: bz_valid=0, counters cleared, bz unchanged.
  - Abort has priority over sample acceptance and over bz_ready in the same cycle.
  - Abort in IDLE has no effect; start in the same cycle is still honoured.
- Result arithmetic
  - Counters n and c are TW+1 bits wide.
  - bz = c << (W − ell_q), truncated to TW bits.
  - Saturation: if c = 2^(ell_q+NC) (every sample was 1), bz = 2^TW − 1.
  - c = 0 gives bz = 0.
- start is ignored outside IDLE, including in the HOLD cycle where bz_ready completes the handshake.
- ell and abort are don't-care whenever no conversion is active.

## Timing
- Reset values: state=IDLE, z_ready=0, bz_valid=0, bz=0, busy=0, n=c=0. Reset in any state returns to these values on the next edge and discards any partial conversion.
- Start accepted at edge t: z_ready=1 and busy=1 from cycle t+1.
- Final sample accepted at edge k: bz_valid=1 and z_ready=0 from cycle k+1. Minimum latency from start to bz_valid is 2^(ell_q+NC)+1 cycles.
- Handshake completes at edge h: IDLE in cycle h+1. The earliest next start is accepted at edge h+1.
- bz_valid stays high until bz_ready, with no timeout.
- There is no combinational path from bz_ready or z_valid to z_ready. z_ready and bz_valid are decoded from state only.

## Test plan
Bench parameters: W=4, NC=1, TW=5.
- Nominal: start with ell=2 (window of 8); send z=1,0,1,1,0,1,0,1 with z_valid held high → bz=20 (5<<2), bz_valid asserted the cycle after the 8th sample, 9 cycles after start.
- Saturation and minimum: ell=4 with 32 ones → bz=31. ell=0 with z=1,0 → bz=16. ell=0 with z=0,0 → bz=0.
- Clamp and stalls: ell=7 → window of 32 (clamped to 4). Insert z_valid=0 gaps of 1–3 cycles; 16 ones → bz=16. Ignored samples must not count.
- Output backpressure: hold bz_ready=0 for 10 cycles → bz and bz_valid stable, z_ready=0. Pulse start during HOLD → ignored. Release bz_ready → IDLE; a new start in the following cycle is accepted.
- Abort: abort after 3 samples in ACC → IDLE, no bz_valid; the next conversion (ell=1, 4 samples, 2 ones) gives bz=16. Abort together with bz_ready in HOLD → IDLE, bz_valid=0.
- Reset: assert rst_n=0 mid-ACC and mid-HOLD → all outputs take their reset values on the next edge. A fresh conversion afterwards matches the scoreboard (bz = c<<(W−ell) with saturation).

Source files
------------

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones over a 2^(ell+NC) sample window of a stochastic stream and returns a TW-bit estimate
//   i_clk, i_rst_n (sync, active-low)
//   i_start, i_ell    : begin a conversion at precision ell (clamped to W)
//   i_abort           : drop an in-flight conversion
//   i_z, i_z_valid    : stream input, o_z_ready accepts it
//   o_bz, o_bz_valid  : result output, taken by i_bz_ready
//   o_busy            : conversion in ACC or HOLD
module sc_stream_decoder #(
    parameter  int W  = 8,
    parameter  int NC = 0,
    localparam int TW = W + NC,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [LW-1:0] i_ell,
    input  logic          i_abort,
    input  logic          i_z,
    input  logic          i_z_valid,
    output logic          o_z_ready,
    output logic [TW-1:0] o_bz,
    output logic          o_bz_valid,
    input  logic          i_bz_ready,
    output logic          o_busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    logic [1:0]    r_state;
    logic [LW-1:0] r_ell;
    logic [TW:0]   r_n;
    logic [TW:0]   r_c;
    logic [TW-1:0] r_bz;
    logic          w_acc;
    logic [TW:0]   w_n_next;
    logic [TW:0]   w_c_next;
    logic [TW:0]   w_win;
    logic [LW-1:0] w_sh;
    logic [TW:0]   w_scaled;
    logic [TW-1:0] w_bz;
    logic [LW-1:0] w_ell_clamp;
    always_comb begin
        w_acc       = (r_state == S_ACC) && i_z_valid;
        w_n_next    = r_n + (TW+1)'(1);
        w_c_next    = r_c + (TW+1)'(i_z);
        w_win       = (TW+1)'(1) << (int'(r_ell) + NC);
        w_sh        = LW'(W) - r_ell;
        w_scaled    = w_c_next << w_sh;
        // all-ones window would scale to exactly 2^TW, which does not fit; saturate instead
        w_bz        = (w_c_next == w_win) ? {TW{1'b1}} : w_scaled[TW-1:0];
        w_ell_clamp = (i_ell > LW'(W)) ? LW'(W) : i_ell;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ell   <= '0;
            r_n     <= '0;
            r_c     <= '0;
            r_bz    <= '0;
        end else if (i_abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_c     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_ACC;
                    r_ell   <= w_ell_clamp;
                    r_n     <= '0;
                    r_c     <= '0;
                end
                S_ACC: if (w_acc) begin
                    r_n <= w_n_next;
                    r_c <= w_c_next;
                    if (w_n_next == w_win) begin
                        r_bz    <= w_bz;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: if (i_bz_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_z_ready  = (r_state == S_ACC);
    assign o_bz_valid = (r_state == S_HOLD);
    assign o_busy     = (r_state == S_ACC) || (r_state == S_HOLD);
    assign o_bz       = r_bz;
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: scoreboard bench for sc_stream_decoder with W=4, NC=1
module tb_sc_stream_decoder;
    localparam int W  = 4;
    localparam int NC = 1;
    localparam int TW = 5;
    localparam int LW = 3;
    logic          clk = 0, rst_n = 0, start = 0, abort = 0, z = 0, z_valid = 0, bz_ready = 0;
    logic [LW-1:0] ell = '0;
    logic          z_ready, bz_valid, busy;
    logic [TW-1:0] bz;
    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    sc_stream_decoder #(.W(W), .NC(NC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ell(ell), .i_abort(abort),
        .i_z(z), .i_z_valid(z_valid), .o_z_ready(z_ready), .o_bz(bz),
        .o_bz_valid(bz_valid), .i_bz_ready(bz_ready), .o_busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int e, input int c);
        int ee;
        ee = (e > W) ? W : e;
        if (c == (1 << (ee + NC))) return (1 << TW) - 1;
        return (c << (W - ee)) & ((1 << TW) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input int e);
        ell   = LW'(e);
        start = 1;
        step();
        start = 0;
    endtask

    // gaps: z_valid=0 for 1-3 cycles between samples, with z=1 so a counted gap shows up
    task automatic send(input logic [31:0] bits, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            z       = bits[i];
            z_valid = 1;
            if (i == len - 1) chk("valid_before_last", int'(bz_valid), 0);
            step();
            if (gaps && i < len - 1) begin
                z_valid = 0;
                z       = 1;
                repeat ((i % 3) + 1) step();
            end
        end
        z_valid = 0;
        z       = 0;
        chk("valid_after_last", int'(bz_valid), 1);
        chk("zready_in_hold", int'(z_ready), 0);
    endtask

    task automatic run(input int e, input logic [31:0] bits, input int len, input bit gaps,
                       input int exp, input bit ready);
        bz_ready = ready;
        exp_q.push_back(exp);
        start_conv(e);
        chk("busy_after_start", int'(busy), 1);
        chk("zready_after_start", int'(z_ready), 1);
        send(bits, len, gaps);
        if (ready) begin
            step();
            chk("idle_after_hs", int'(busy), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bz_valid && bz_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got bz=%0d expected no result", bz);
            end else begin
                chk("sb_bz", int'(bz), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        chk("rst_zready", int'(z_ready), 0);
        chk("rst_bz_valid", int'(bz_valid), 0);
        chk("rst_bz", int'(bz), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1;
        step();
        // nominal, saturation, minimum window
        run(2, 32'hAD, 8, 0, 20, 1);
        run(4, 32'hFFFF_FFFF, 32, 0, 31, 1);
        run(0, 32'h1, 2, 0, 16, 1);
        run(0, 32'h0, 2, 0, 0, 1);
        // clamp ell=7 to 4 with stalls
        run(7, 32'h5555_5555, 32, 1, 16, 1);
        // output backpressure with ignored start in HOLD
        run(1, 32'h7, 4, 0, 24, 0);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            ell   = '0;
            step();
            chk("bp_valid", int'(bz_valid), 1);
            chk("bp_bz", int'(bz), 24);
            chk("bp_zready", int'(z_ready), 0);
        end
        bz_ready = 1;
        start    = 1;
        ell      = '0;
        exp_q.push_back(31);
        step();
        chk("start_in_hs_ignored", int'(busy), 0);
        step();
        chk("restart_busy", int'(busy), 1);
        chk("restart_zready", int'(z_ready), 1);
        start = 0;
        send(32'h3, 2, 0);
        step();
        chk("restart_idle", int'(busy), 0);
        // abort in ACC
        start_conv(2);
        z = 1;
        z_valid = 1;
        repeat (3) step();
        abort = 1;
        step();
        abort   = 0;
        z_valid = 0;
        chk("abort_acc_busy", int'(busy), 0);
        chk("abort_acc_zready", int'(z_ready), 0);
        chk("abort_acc_valid", int'(bz_valid), 0);
        run(1, 32'h9, 4, 0, 16, 1);
        // abort together with bz_ready in HOLD
        bz_ready = 0;
        start_conv(0);
        send(32'h3, 2, 0);
        abort    = 1;
        bz_ready = 1;
        step();
        abort    = 0;
        bz_ready = 0;
        chk("abort_hold_valid", int'(bz_valid), 0);
        chk("abort_hold_busy", int'(busy), 0);
        chk("abort_hold_bz", int'(bz), 31);
        // reset mid-ACC
        start_conv(3);
        z = 1;
        z_valid = 1;
        repeat (4) step();
        rst_n = 0;
        step();
        chk("rst_acc_zready", int'(z_ready), 0);
        chk("rst_acc_valid", int'(bz_valid), 0);
        chk("rst_acc_busy", int'(busy), 0);
        chk("rst_acc_bz", int'(bz), 0);
        rst_n   = 1;
        z_valid = 0;
        z       = 0;
        step();
        // reset mid-HOLD
        start_conv(2);
        send(32'hFF, 8, 0);
        chk("pre_rst_hold_bz", int'(bz), 31);
        rst_n = 1'b0;
        step();
        chk("rst_hold_zready", int'(z_ready), 0);
        chk("rst_hold_valid", int'(bz_valid), 0);
        chk("rst_hold_busy", int'(busy), 0);
        chk("rst_hold_bz", int'(bz), 0);
        rst_n = 1;
        step();
        run(3, 32'h5A3C, 16, 0, model(3, $countones(32'h5A3C)), 1);
        run(2, 32'hF7, 8, 0, model(2, $countones(32'hF7)), 1);
        repeat (2) step();
        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
